instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Producer side of the 32-bit instruction word consumed by control_unit.
//  Generates sequential PCs, issues requests to instruction memory and buffers
//  in-order responses in a small FIFO. Presents ir/ir_pc with a valid/ready
//  handshake to decode.
//  Accepts a redirect (jump/branch target) that flushes all buffered and
//  in-flight instructions.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of the first fetch after reset (word aligned)
//  FIFO_DEPTH  4              instruction buffer entries = max in-flight+buffered (power of 2, >=2)
// PORTS
//  clk             in   1   single clock; all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  fetch byte address, [1:0] always 2'b00
//  imem_rsp_valid  in   1   response valid (in order, no backpressure)
//  imem_rsp_data   in   32  instruction word
//  ir_valid        out  1   ir/ir_pc hold a valid instruction
//  ir_ready        in   1   decode consumes ir this cycle
//  ir              out  32  instruction word to control_unit
//  ir_pc           out  32  address of ir
//  redirect        in   1   flush and restart fetch at redirect_pc
//  redirect_pc     in   32  new fetch address; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, inflight=0, drop_cnt=0, ir_valid=0, ir=0,
//    ir_pc=0, imem_req_valid=0 while rst high.
//  - First request is issued in the first cycle after rst deasserts.
//  - State: pc, inflight (0..FIFO_DEPTH), drop_cnt (0..FIFO_DEPTH), FIFO (data+pc), count.
//  - Issue: imem_req_valid = !redirect && (inflight + count < FIFO_DEPTH).
//  - imem_req_addr=pc. On valid&&ready: pc<=pc+4, inflight++. pc wraps 32'hFFFF_FFFC->0.
//  - Issue credit guarantees every live response has a FIFO slot; overflow is impossible.
//  - Response: each imem_rsp_valid cycle decrements inflight.
//    If drop_cnt>0 the word is discarded and drop_cnt--; else pushed with its
//    pc (tracked by a response-pc counter advancing by 4).
//  - Output: ir/ir_pc = FIFO head, ir_valid = (count!=0). Pop on ir_valid&&ir_ready.
//  - Latency: rsp into empty FIFO -> ir_valid high next cycle. No combinational rsp->ir path.
//  - Simultaneous push+pop: count unchanged, head advances.
//  - Redirect (highest priority, single cycle):
//    - FIFO flushed (count=0, ir_valid=0 next cycle); any same-cycle pop or push is ignored.
//    - pc<=redirect_pc & ~3; response-pc counter <= same.
//    - No request issued in the redirect cycle.
//    - drop_cnt <= inflight - imem_rsp_valid (every request still outstanding is stale).
//  - Back-to-back redirects: each recomputes drop_cnt from current inflight; last target wins.
//  - Requests to the new target issue from the cycle after redirect, even while
//    drop_cnt>0; the credit check counts stale in-flight entries.
//  - ir_ready with ir_valid=0 has no effect; ir holds its value while ir_valid&&!ir_ready.
// TESTING
//  1. Reset release, ready=1, 1-cycle rsp latency, ir_ready=1 -> addrs 0,4,8,...;
//     ir_pc sequence 0,4,8 with matching data.
//  2. ir_ready=0 held -> exactly 4 requests issued (DEPTH=4), req_valid drops,
//     ir holds pc 0. Release ready -> one pop per cycle, fetch resumes at 16.
//  3. 3 requests in flight, redirect to 32'h0000_0103 -> next req addr 0x100;
//     the 3 stale rsps are dropped; first ir_pc=0x100.
//  4. Redirect in same cycle as imem_rsp_valid and ir_ready -> that rsp dropped,
//     drop_cnt=inflight-1; ir_valid=0 next cycle.
//  5. imem_req_ready toggling randomly, variable rsp latency, random redirects ->
//     scoreboard: ir_pc stream matches the reference PC model.
//     No FIFO overflow; inflight never exceeds FIFO_DEPTH.
//  6. rst asserted mid-stream with rsps pending -> all outputs zero immediately;
//     after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the decode-side ir channel.
// Each handshake completes on a rising edge where valid && ready are both high.
// Valid never waits for ready. Responses have no ready and arrive in request order.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, ir_valid, ir, ir_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, ir_valid, ir, ir_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential PC requests under a credit limit, buffers in-order
// responses in a small FIFO and presents them to decode; a redirect flushes and restarts fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  instr_fetch_unit_if.master          bus,
  output logic [$clog2(FIFO_DEPTH):0] o_dbg_inflight,
  output logic [$clog2(FIFO_DEPTH):0] o_dbg_drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] o_dbg_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_data [FIFO_DEPTH];
  logic [31:0]   r_pcbuf[FIFO_DEPTH];

  logic        w_credit;
  logic        w_req_valid;
  logic        w_req_fire;
  logic        w_rsp;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_target;

  // Stale in-flight requests still hold credit, so a live response always finds a free slot.
  always_comb begin
    w_credit    = ({1'b0, r_inflight} + {1'b0, r_count}) < (CW + 1)'(FIFO_DEPTH);
    w_req_valid = !rst && !bus.redirect && w_credit;
    w_req_fire  = w_req_valid && bus.imem_req_ready;
    w_rsp       = bus.imem_rsp_valid;
    w_drop      = w_rsp && (r_drop_cnt != '0);
    w_push      = w_rsp && !w_drop && !bus.redirect;
    w_pop       = (r_count != '0) && bus.ir_ready && !bus.redirect;
    w_target    = bus.redirect_pc & ~32'h0000_0003;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i]  <= '0;
        r_pcbuf[i] <= '0;
      end
    end else if (bus.redirect) begin
      // Everything still outstanding after this cycle belongs to the old path.
      r_pc       <= w_target;
      r_rsp_pc   <= w_target;
      r_inflight <= r_inflight - CW'(w_rsp);
      r_drop_cnt <= r_inflight - CW'(w_rsp);
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      if (w_req_fire) begin
        r_pc <= r_pc + 32'd4;
      end
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp);
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
      if (w_push) begin
        r_data[r_wptr]  <= bus.imem_rsp_data;
        r_pcbuf[r_wptr] <= r_rsp_pc;
        r_wptr          <= r_wptr + 1'b1;
        r_rsp_pc        <= r_rsp_pc + 32'd4;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.ir_valid       = (r_count != '0);
  assign bus.ir             = r_data[r_rptr];
  assign bus.ir_pc          = r_pcbuf[r_rptr];

  assign o_dbg_inflight = r_inflight;
  assign o_dbg_drop_cnt = r_drop_cnt;
  assign o_dbg_count    = r_count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a latency-randomised memory model, a queue of expected ir PCs
// and a stale-response counter predict every output cycle by cycle.
module tb_instr_fetch_unit;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();
  logic [2:0] dbg_inflight, dbg_drop, dbg_count;

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .o_dbg_inflight (dbg_inflight),
    .o_dbg_drop_cnt (dbg_drop),
    .o_dbg_count    (dbg_count)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          stale    = 0;
  int          n_req    = 0;
  bit          rel_pending = 1'b0;
  logic [31:0] exp_req  = RST_PC;
  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check just after, then apply the handshakes to the model.
  task automatic step(input bit rq, input bit ir_r, input bit rd, input logic [31:0] rpc);
    bit          rsp_now;
    bit          fire;
    bit          popped;
    bit          exp_rv;
    int          infl;
    logic [31:0] rsp_addr;
    @(negedge clk);
    cyc++;
    if (rel_pending) begin
      rst = 1'b0;
      rel_pending = 1'b0;
    end
    bus.imem_req_ready = rq;
    bus.ir_ready       = ir_r;
    bus.redirect       = rd;
    bus.redirect_pc    = rd ? rpc : $urandom;
    rsp_now  = 1'b0;
    rsp_addr = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_now  = 1'b1;
      rsp_addr = mem_q[0].addr;
      void'(mem_q.pop_front());
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(rsp_addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    infl = mem_q.size() + int'(rsp_now);
    chk("inflight", 32'(dbg_inflight), 32'(infl));
    chk("inflight_le_depth", 32'(dbg_inflight <= 3'(DEPTH)), 32'd1);
    chk("buffered_le_depth", 32'(exp_q.size() <= DEPTH), 32'd1);
    chk("drop_cnt", 32'(dbg_drop), 32'(stale));
    chk("ir_valid", 32'(bus.ir_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("ir_pc", bus.ir_pc, exp_q[0]);
      chk("ir", bus.ir, mem_word(exp_q[0]));
    end
    exp_rv = !rd && (infl + exp_q.size() < DEPTH);
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_req);
    fire   = bus.imem_req_valid && rq;
    popped = bus.ir_valid && ir_r;
    if (rd) begin
      stale = mem_q.size();
      exp_q.delete();
      exp_req = rpc & ~32'h3;
    end else begin
      if (popped && exp_q.size() != 0) pop_log.push_back(exp_q.pop_front());
      if (rsp_now) begin
        if (stale > 0) stale--;
        else exp_q.push_back(rsp_addr);
      end
      if (fire) begin
        mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + $urandom_range(lat_min, lat_max)});
        req_log.push_back(bus.imem_req_addr);
        exp_req = exp_req + 32'd4;
        n_req++;
      end
    end
  endtask

  // Asynchronous assert away from any edge; release is applied by the next step().
  task automatic do_reset();
    #3;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.ir_ready       = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    chk("rst_ir", bus.ir, 32'd0);
    chk("rst_ir_pc", bus.ir_pc, 32'd0);
    chk("rst_inflight", 32'(dbg_inflight), 32'd0);
    chk("rst_drop", 32'(dbg_drop), 32'd0);
    chk("rst_count", 32'(dbg_count), 32'd0);
    mem_q.delete();
    exp_q.delete();
    pop_log.delete();
    req_log.delete();
    stale   = 0;
    n_req   = 0;
    exp_req = RST_PC;
    repeat (2) @(posedge clk);
    rel_pending = 1'b1;
  endtask

  initial begin
    int pre;
    bit ready_cond;
    do_reset();

    // Sequential fetch with 1-cycle memory and an always-ready decoder.
    lat_min = 1; lat_max = 1;
    step(1, 1, 0, '0);
    chk("t1_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t1_first_req_addr", bus.imem_req_addr, RST_PC);
    repeat (10) step(1, 1, 0, '0);
    chk("t1_pop0", qat(pop_log, 0), 32'h0);
    chk("t1_pop1", qat(pop_log, 1), 32'h4);
    chk("t1_pop2", qat(pop_log, 2), 32'h8);

    // Decoder stalled: fetch stops at the credit limit and ir holds the first word.
    do_reset();
    repeat (10) step(1, 0, 0, '0);
    chk("t2_req_count", 32'(n_req), 32'(DEPTH));
    chk("t2_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_ir_pc_hold", bus.ir_pc, 32'h0);
    chk("t2_ir_hold", bus.ir, mem_word(32'h0));
    pop_log.delete();
    req_log.delete();
    repeat (4) step(1, 1, 0, '0);
    chk("t2_pops", 32'(pop_log.size()), 32'd4);
    chk("t2_pop3", qat(pop_log, 3), 32'hC);
    chk("t2_resume_addr", qat(req_log, 0), 32'h10);

    // Redirect with three long-latency requests outstanding.
    do_reset();
    lat_min = 8; lat_max = 8;
    repeat (3) step(1, 1, 0, '0);
    step(0, 1, 0, '0);
    step(1, 1, 1, 32'h0000_0103);
    req_log.delete();
    pop_log.delete();
    step(1, 1, 0, '0);
    chk("t3_drop_cnt", 32'(dbg_drop), 32'd3);
    chk("t3_new_addr", qat(req_log, 0), 32'h0000_0100);
    repeat (24) step(1, 1, 0, '0);
    chk("t3_first_ir_pc", qat(pop_log, 0), 32'h0000_0100);
    chk("t3_second_ir_pc", qat(pop_log, 1), 32'h0000_0104);

    // Redirect in the same cycle as a response and a pop.
    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (8) step(1, 1, 0, '0);
    ready_cond = 1'b0;
    for (int i = 0; i < 50; i++) begin
      ready_cond = mem_q.size() > 0 && mem_q[0].due <= cyc + 1 && exp_q.size() != 0;
      if (ready_cond) break;
      step(1, 1, 0, '0);
    end
    chk("t4_setup_reached", 32'(ready_cond), 32'd1);
    pre = mem_q.size();
    step(1, 1, 1, 32'h0000_0200);
    step(1, 1, 0, '0);
    chk("t4_ir_valid_low", 32'(bus.ir_valid), 32'd0);
    chk("t4_drop_cnt", 32'(dbg_drop), 32'(pre - 1));

    // PC wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    step(1, 1, 1, 32'hFFFF_FFFA);
    req_log.delete();
    repeat (6) step(1, 1, 0, '0);
    chk("wrap_a0", qat(req_log, 0), 32'hFFFF_FFF8);
    chk("wrap_a1", qat(req_log, 1), 32'hFFFF_FFFC);
    chk("wrap_a2", qat(req_log, 2), 32'h0000_0000);

    // Random stall, latency and redirect traffic.
    lat_min = 1; lat_max = 5;
    repeat (1500) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, rpc);
    end

    // Reset in the middle of traffic with responses pending.
    lat_min = 3; lat_max = 5;
    repeat (30) step(1, $urandom_range(0, 1) == 1, 1'b0, '0);
    chk("t6_pending_before_rst", 32'(mem_q.size() > 0), 32'd1);
    do_reset();
    step(1, 1, 0, '0);
    chk("t6_restart_addr", qat(req_log, 0), RST_PC);
    repeat (30) step($urandom_range(0, 3) != 0, 1'b1, 1'b0, '0);
    chk("t6_first_ir_pc", qat(pop_log, 0), RST_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
